// File: rtl/input_sequencer_pkg.sv
// Shared types and default constants for the push-button input sequencer.
package input_sequencer_pkg;

  localparam int DEBOUNCE_N_DEFAULT  = 4;
  localparam int QUEUE_DEPTH_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Arbiter state kept as one struct so checkers can bind to a single signal.
  typedef struct packed {
    arb_state_t state;
    logic       prio;      // 0 favours inp_0, 1 favours inp_1
    logic       hold_bit;  // loser of a simultaneous press, pushed in HOLD
  } arb_dbg_t;

endpackage

// File: rtl/input_sequencer_debounce_cell.sv
// One push-button channel: 2-flop synchronizer, tick-driven debounce counter,
// stable level, and a one-cycle press pulse on the accepted 0->1 transition.
module debounce_cell #(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic tick,
  input  logic raw,
  output logic press
);

  localparam logic [3:0] LAST = 4'(DEBOUNCE_N - 1);

  logic       sync_1;
  logic       sync_2;
  logic       stable;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (tick) begin
        if (sync_2 == stable) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          // Accept the new level; only a rising level is a press.
          stable <= sync_2;
          cnt    <= '0;
          press  <= sync_2;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/input_sequencer.sv
// Two debounced push-buttons arbitrated into a first-word-fall-through queue
// of bit events (0 = inp_0 press, 1 = inp_1 press).
module input_sequencer
  import input_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_N  = DEBOUNCE_N_DEFAULT,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic                           clk_125,
  input  logic                           clear,
  input  logic                           tick,
  input  logic                           inp_0,
  input  logic                           inp_1,
  input  logic                           bit_ready,
  output logic                           bit_valid,
  output logic                           bit_data,
  output logic [$clog2(QUEUE_DEPTH):0]   pending_count,
  output logic                           overflow
);

  localparam int           AW     = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0]  FULL   = (AW + 1)'(QUEUE_DEPTH);
  localparam logic [AW:0]  CNT_1  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_1 = AW'(1);

  logic press_0;
  logic press_1;

  debounce_cell #(.DEBOUNCE_N(DEBOUNCE_N)) u_cell_0 (
    .clk   (clk_125),
    .clear (clear),
    .tick  (tick),
    .raw   (inp_0),
    .press (press_0)
  );

  debounce_cell #(.DEBOUNCE_N(DEBOUNCE_N)) u_cell_1 (
    .clk   (clk_125),
    .clear (clear),
    .tick  (tick),
    .raw   (inp_1),
    .press (press_1)
  );

  arb_dbg_t arb_q;
  arb_dbg_t arb_d;
  logic     push;
  logic     push_data;

  always_comb begin
    arb_d     = arb_q;
    push      = 1'b0;
    push_data = 1'b0;
    case (arb_q.state)
      IDLE: begin
        if (press_0 && press_1) begin
          push           = 1'b1;
          push_data      = arb_q.prio;
          arb_d.hold_bit = ~arb_q.prio;
          arb_d.prio     = ~arb_q.prio;
          arb_d.state    = HOLD;
        end else if (press_0) begin
          push      = 1'b1;
          push_data = 1'b0;
        end else if (press_1) begin
          push      = 1'b1;
          push_data = 1'b1;
        end
      end
      HOLD: begin
        // Tick spacing rules out a fresh press here, so presses are not looked at.
        push        = 1'b1;
        push_data   = arb_q.hold_bit;
        arb_d.state = IDLE;
      end
      default: arb_d.state = IDLE;
    endcase
  end

  // Handshake: an event transfers on every rising clk_125 edge where
  // bit_valid && bit_ready; bit_valid never depends on bit_ready, and
  // bit_ready while empty has no effect.
  logic          mem_q [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          pop;
  logic          full;
  logic          push_ok;

  assign pop     = bit_valid && bit_ready;
  assign full    = (count_q == FULL);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_125 or posedge clear) begin
    if (clear) begin
      arb_q      <= '{state: IDLE, prio: 1'b0, hold_bit: 1'b0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      arb_q <= arb_d;
      if (push_ok) wr_ptr <= wr_ptr + PTR_1;
      if (pop)     rd_ptr <= rd_ptr + PTR_1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_1;
        2'b01:   count_q <= count_q - CNT_1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: bit_data is masked whenever the queue is empty.
  always_ff @(posedge clk_125) begin
    if (push_ok) mem_q[wr_ptr] <= push_data;
  end

  assign bit_valid     = (count_q != '0);
  assign bit_data      = bit_valid & mem_q[rd_ptr];
  assign pending_count = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_input_sequencer.sv
// Self-checking bench for input_sequencer: directed scenarios plus random
// button patterns checked against an event-level model of the buttons.
module tb_input_sequencer;

  localparam int N  = 4;
  localparam int QD = 4;

  logic       clk_125;
  logic       clear;
  logic       tick;
  logic       inp_0;
  logic       inp_1;
  logic       bit_ready;
  logic       bit_valid;
  logic       bit_data;
  logic [2:0] pending_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  // Model: a level is accepted once it has differed from the accepted level
  // on N consecutive ticks; presses are accepted 0->1 transitions.
  bit          m_stable [2];
  int unsigned m_since  [2];
  int unsigned tick_n;
  bit          m_prio;
  bit          m_ovf;
  logic [0:0]  exp_q[$];

  input_sequencer #(.DEBOUNCE_N(N), .QUEUE_DEPTH(QD)) dut (
    .clk_125       (clk_125),
    .clear         (clear),
    .tick          (tick),
    .inp_0         (inp_0),
    .inp_1         (inp_1),
    .bit_ready     (bit_ready),
    .bit_valid     (bit_valid),
    .bit_data      (bit_data),
    .pending_count (pending_count),
    .overflow      (overflow)
  );

  // Clock / reset
  initial begin
    clk_125 = 1'b0;
    forever #4 clk_125 = ~clk_125;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Model
  task automatic model_reset();
    m_stable[0] = 1'b0; m_stable[1] = 1'b0;
    m_since[0]  = 0;    m_since[1]  = 0;
    tick_n = 0;
    m_prio = 1'b0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_push(input bit v);
    if (exp_q.size() < QD) exp_q.push_back(v);
    else m_ovf = 1'b1;
  endtask

  task automatic model_tick();
    bit lvl [2];
    bit p   [2];
    tick_n++;
    lvl[0] = inp_0;
    lvl[1] = inp_1;
    for (int i = 0; i < 2; i++) begin
      p[i] = 1'b0;
      if (lvl[i] == m_stable[i]) begin
        m_since[i] = tick_n;
      end else if (tick_n - m_since[i] >= N) begin
        m_stable[i] = lvl[i];
        m_since[i]  = tick_n;
        p[i]        = lvl[i];
      end
    end
    if (p[0] && p[1]) begin
      model_push(m_prio);
      model_push(~m_prio);
      m_prio = ~m_prio;
    end else if (p[0]) begin
      model_push(1'b0);
    end else if (p[1]) begin
      model_push(1'b1);
    end
  endtask

  function automatic void load_exp(input logic [7:0] bits, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk_125);
    #1;
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    model_tick();
    step();
    tick = 1'b0;
  endtask

  task automatic run_ticks(input int k);
    repeat (k) begin
      repeat (3) step();
      do_tick();
    end
  endtask

  task automatic do_reset();
    clear     = 1'b1;
    tick      = 1'b0;
    bit_ready = 1'b0;
    inp_0     = 1'b0;
    inp_1     = 1'b0;
    step();
    step();
    clear = 1'b0;
    model_reset();
    step();
  endtask

  task automatic press(input bit which);
    if (which) inp_1 = 1'b1; else inp_0 = 1'b1;
    run_ticks(N);
    inp_0 = 1'b0;
    inp_1 = 1'b0;
    run_ticks(N);
  endtask

  // Scoreboard drain: pop everything, comparing head against the expected queue.
  task automatic drain_check(input string name);
    logic [0:0] v;
    bit_ready = 1'b1;
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      checks++;
      if (bit_valid !== 1'b1 || bit_data !== v) begin
        errors++;
        $display("FAIL %s: got valid=%0b data=%0b expected valid=1 data=%0b",
                 name, bit_valid, bit_data, v);
      end
      step();
    end
    bit_ready = 1'b0;
    checks++;
    if (bit_valid !== 1'b0 || pending_count !== 3'd0) begin
      errors++;
      $display("FAIL %s_empty: got valid=%0b count=%0d expected valid=0 count=0",
               name, bit_valid, pending_count);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    clear = 1'b1;
    #1;
    checks++;
    if (bit_valid !== 1'b0 || bit_data !== 1'b0 || pending_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b data=%0b count=%0d ovf=%0b expected all 0",
               bit_valid, bit_data, pending_count, overflow);
    end
    do_reset();
  endtask

  task automatic test_single_press();
    do_reset();
    inp_1 = 1'b1;
    run_ticks(N - 1);
    settle();
    checks++;
    if (bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got valid=%0b expected 0", bit_valid);
    end
    do_tick();
    checks++;
    if (bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_before_write: got valid=%0b expected 0", bit_valid);
    end
    step();
    checks++;
    if (bit_valid !== 1'b1 || bit_data !== 1'b1 || pending_count !== 3'd1) begin
      errors++;
      $display("FAIL single_latency: got valid=%0b data=%0b count=%0d expected 1 1 1",
               bit_valid, bit_data, pending_count);
    end
    inp_1 = 1'b0;
    run_ticks(N);
    settle();
    checks++;
    if (pending_count !== 3'd1) begin
      errors++;
      $display("FAIL release_no_event: got count=%0d expected 1", pending_count);
    end
    load_exp(8'b1, 1);
    drain_check("single_drain");
  endtask

  task automatic test_glitch();
    do_reset();
    inp_0 = 1'b1;
    run_ticks(N - 1);
    inp_0 = 1'b0;
    run_ticks(2);
    settle();
    checks++;
    if (pending_count !== 3'd0 || bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got count=%0d valid=%0b expected 0 0", pending_count, bit_valid);
    end
    inp_0 = 1'b1;
    run_ticks(N - 1);
    settle();
    checks++;
    if (pending_count !== 3'd0) begin
      errors++;
      $display("FAIL glitch_counter_cleared: got count=%0d expected 0", pending_count);
    end
    run_ticks(1);
    settle();
    checks++;
    if (pending_count !== 3'd1 || bit_data !== 1'b0) begin
      errors++;
      $display("FAIL glitch_then_press: got count=%0d data=%0b expected 1 0", pending_count, bit_data);
    end
    inp_0 = 1'b0;
    run_ticks(N);
    load_exp(8'b0, 1);
    drain_check("glitch_drain");
  endtask

  task automatic test_simultaneous();
    do_reset();
    inp_0 = 1'b1;
    inp_1 = 1'b1;
    run_ticks(N);
    step();
    checks++;
    if (pending_count !== 3'd1 || bit_data !== 1'b0) begin
      errors++;
      $display("FAIL simul_first: got count=%0d data=%0b expected 1 0", pending_count, bit_data);
    end
    step();
    checks++;
    if (pending_count !== 3'd2) begin
      errors++;
      $display("FAIL simul_held: got count=%0d expected 2", pending_count);
    end
    inp_0 = 1'b0; inp_1 = 1'b0;
    run_ticks(N);
    inp_0 = 1'b1; inp_1 = 1'b1;
    run_ticks(N);
    inp_0 = 1'b0; inp_1 = 1'b0;
    run_ticks(N);
    settle();
    checks++;
    if (pending_count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL simul_count: got count=%0d ovf=%0b expected 4 0", pending_count, overflow);
    end
    load_exp(8'b0110, 4);
    drain_check("simul_order");
  endtask

  task automatic test_overflow();
    do_reset();
    press(0); press(1); press(0); press(1); press(1);
    settle();
    checks++;
    if (pending_count !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: got count=%0d ovf=%0b expected 4 1", pending_count, overflow);
    end
    load_exp(8'b1010, 4);
    drain_check("overflow_order");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %0b expected 1", overflow);
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %0b expected 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    press(0); press(1); press(1); press(0);
    settle();
    inp_1 = 1'b1;
    run_ticks(N - 1);
    settle();
    void'(exp_q.pop_front());
    do_tick();
    bit_ready = 1'b1;
    checks++;
    if (bit_data !== 1'b0 || pending_count !== 3'd4) begin
      errors++;
      $display("FAIL full_pop_head: got data=%0b count=%0d expected 0 4", bit_data, pending_count);
    end
    step();
    bit_ready = 1'b0;
    checks++;
    if (pending_count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_push: got count=%0d ovf=%0b expected 4 0", pending_count, overflow);
    end
    inp_1 = 1'b0;
    run_ticks(N);
    settle();
    load_exp(8'b1011, 4);
    drain_check("full_pop_order");
  endtask

  task automatic test_clear_hold();
    do_reset();
    press(1);
    settle();
    inp_0 = 1'b1;
    inp_1 = 1'b1;
    run_ticks(N);
    step();
    checks++;
    if (pending_count !== 3'd2) begin
      errors++;
      $display("FAIL hold_count: got %0d expected 2", pending_count);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (bit_valid !== 1'b0 || bit_data !== 1'b0 || pending_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_async: got valid=%0b data=%0b count=%0d ovf=%0b expected all 0",
               bit_valid, bit_data, pending_count, overflow);
    end
    step();
    clear = 1'b0;
    model_reset();
    run_ticks(N - 1);
    settle();
    checks++;
    if (pending_count !== 3'd0) begin
      errors++;
      $display("FAIL no_held_event: got count=%0d expected 0", pending_count);
    end
    run_ticks(1);
    settle();
    checks++;
    if (pending_count !== 3'd2) begin
      errors++;
      $display("FAIL fresh_debounce: got count=%0d expected 2", pending_count);
    end
    inp_0 = 1'b0;
    inp_1 = 1'b0;
    run_ticks(N);
    load_exp(8'b10, 2);
    drain_check("after_clear_order");
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      repeat (8) begin
        inp_0 = 1'($urandom_range(0, 1));
        inp_1 = 1'($urandom_range(0, 1));
        run_ticks($urandom_range(2, 6));
      end
      settle();
      checks++;
      if (pending_count !== 3'(exp_q.size()) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random_round%0d: got count=%0d ovf=%0b expected count=%0d ovf=%0b",
                 r, pending_count, overflow, exp_q.size(), m_ovf);
      end
      drain_check("random_drain");
    end
  endtask

  initial begin
    clear     = 1'b1;
    tick      = 1'b0;
    inp_0     = 1'b0;
    inp_1     = 1'b0;
    bit_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_clear_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_N, default 4: consecutive differing tick samples needed to accept a new input level (range 2..15).
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 4: event queue depth (power of two, 2..8).
REQ-003 The block SHALL have port clk_125  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port tick  input  1  one-cycle sample strobe from the clock divider (200 Hz rate).
REQ-006 The block SHALL have port inp_0  input  1  raw push-button for bit value 0, asynchronous to clk_125.
REQ-007 The block SHALL have port inp_1  input  1  raw push-button for bit value 1, asynchronous to clk_125.
REQ-008 The block SHALL have port bit_ready  input  1  FSM consumer accepts the head event.
REQ-009 The block SHALL have port bit_valid  output  1  queue non-empty; head event available.
REQ-010 The block SHALL have port bit_data  output  1  head event value (0 = inp_0 press, 1 = inp_1 press).
REQ-011 The block SHALL have port pending_count  output  $clog2(QUEUE_DEPTH)+1  queue occupancy, 0..QUEUE_DEPTH.
REQ-012 The block SHALL have port overflow  output  1  sticky; an event was dropped.

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer clocked every clk_125 cycle.
REQ-014 Debounce per input: on tick, synchronized level != stable level -> counter+1; equal -> counter=0; no tick -> hold.
REQ-015 Stable level SHALL flip, and the counter clear, on the tick where the counter would reach DEBOUNCE_N.
REQ-016 Press event SHALL be a one-cycle pulse in the cycle stable level goes 0->1; 1->0 produces no event.
REQ-017 Arbiter states: IDLE, HOLD; reset -> IDLE, priority pointer = inp_0.
REQ-018 IDLE, single press: enqueue that event this cycle; stay IDLE.
REQ-019 IDLE, simultaneous presses: enqueue pointer-favoured event, latch the other in a hold register, toggle pointer, go HOLD.
REQ-020 HOLD: enqueue held event next cycle, return IDLE; a new press in that cycle is impossible (tick spacing) and SHALL be ignored by design.
REQ-021 Queue SHALL be first-word-fall-through: bit_valid = occupancy>0, bit_data = head, both combinational from registered state.
REQ-022 Pop SHALL occur when bit_valid && bit_ready; bit_ready with empty queue SHALL be ignored.
REQ-023 Push when full SHALL succeed only if a pop occurs the same cycle; occupancy unchanged.
REQ-024 Push when full without pop: event dropped, overflow set; overflow cleared only by clear.
REQ-025 Read/write pointers SHALL wrap modulo QUEUE_DEPTH; pending_count SHALL update the cycle after push/pop.
REQ-026 Latency, raw press to bit_valid: 2 clk (sync) + DEBOUNCE_N ticks + 1 clk (queue write).

Reset
REQ-027 clear SHALL asynchronously force: bit_valid=0, bit_data=0, pending_count=0, overflow=0.
REQ-028 clear SHALL zero synchronizers, stable levels, debounce counters and hold register, set pointers=0, arbiter IDLE, priority=inp_0.
REQ-029 clear asserted mid-debounce or mid-HOLD SHALL discard the in-progress event; no event after release until a fresh full debounce.

Structure
REQ-030 Package input_sequencer_pkg SHALL hold the arbiter state enum (IDLE, HOLD) and default constants for DEBOUNCE_N and QUEUE_DEPTH.
REQ-031 Sub-module debounce_cell (synchronizer, counter, stable level, press pulse) SHALL be instantiated once per input.
REQ-032 Arbiter and queue SHALL live in input_sequencer itself.

Verification
REQ-033 inp_1 held high 4 ticks, bit_ready=0 -> bit_valid=1, bit_data=1, pending_count=1 one clk after the 4th tick.
REQ-034 inp_0 glitch high for 3 ticks then low -> no event, pending_count stays 0.
REQ-035 inp_0 and inp_1 debounce on same tick after reset -> queue holds 0 then 1; next simultaneous pair -> 1 then 0.
REQ-036 5 presses, bit_ready=0, QUEUE_DEPTH=4 -> pending_count=4, overflow=1, first 4 events retained in order.
REQ-037 Queue full, press completes in same cycle as pop (bit_ready=1) -> no overflow, pending_count stays 4, new event at tail.
REQ-038 clear pulsed during HOLD with 2 queued -> all outputs 0 immediately; held event never appears.
